// File: rtl/ibus_rom_responder_pkg.sv
// Shared instruction-bus types and the encoding of the ROM responder's FSM.
package ibus_rom_responder_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef u64          addr_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef logic [1:0] ibus_rsp_state_t;

  localparam ibus_rsp_state_t RSP_IDLE = 2'd0;
  localparam ibus_rsp_state_t RSP_WAIT = 2'd1;
  localparam ibus_rsp_state_t RSP_RESP = 2'd2;

  // Full 64-bit word offset from the store base; wraps when addr < base.
  function automatic u64 word_offset(input addr_t addr, input addr_t base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/ibus_rom_array.sv
// Instruction word store: one synchronous write port and one combinational
// read port that the responder samples on the accepting clock edge.
module ibus_rom_array #(
  parameter  int DEPTH_WORDS = 4096,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Store write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/ibus_rom_responder.sv
// Instruction-bus responder answering fetch requests from a loadable word
// store with a fixed, configurable response latency.
module ibus_rom_responder
  import ibus_rom_responder_pkg::*;
#(
  parameter  int    DEPTH_WORDS = 4096,
  parameter  addr_t BASE_ADDR   = 64'h8000_0000,
  parameter  int    LATENCY     = 1,
  parameter  u32    FILL_WORD   = 32'hd503_201f,
  localparam int    IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  ibus_req_t        ireq,
  output ibus_resp_t       iresp,
  output logic             ierr,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data
);

  localparam u64         DEPTH_U64 = u64'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
  localparam logic       SINGLE_CY = (LATENCY == 32'sd1);

  ibus_rsp_state_t  state_r;
  ibus_rsp_state_t  state_nx_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_nx_s;
  u64               word_off_s;
  logic [IDX_W-1:0] idx_s;
  logic             err_s;
  u32               rd_raw_s;
  u32               rd_word_s;
  logic             addr_ok_s;
  logic             accept_s;
  logic             enter_resp_s;
  logic             from_wait_s;
  logic             data_ok_r;
  u32               data_r;
  logic             ierr_r;
  u32               pend_data_r;
  logic             pend_err_r;

  ibus_rom_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (load_en),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .rd_idx  (idx_s),
    .rd_data (rd_raw_s)
  );

  // Range is judged on the full 64-bit offset so high addresses never alias.
  always_comb begin
    word_off_s = word_offset(ireq.addr, BASE_ADDR);
    idx_s      = word_off_s[IDX_W-1:0];
    err_s      = (ireq.addr[1:0] != 2'b00) || (ireq.addr < BASE_ADDR) ||
                 (word_off_s >= DEPTH_U64);
    rd_word_s  = err_s ? FILL_WORD : rd_raw_s;
  end

  assign addr_ok_s    = ireq.valid && ((state_r == RSP_IDLE) || (state_r == RSP_RESP));
  assign accept_s     = addr_ok_s;
  assign enter_resp_s = (state_nx_s == RSP_RESP);
  assign from_wait_s  = (state_r == RSP_WAIT);

  // Next-state and latency countdown.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      RSP_IDLE, RSP_RESP: begin
        if (accept_s && SINGLE_CY) begin
          state_nx_s = RSP_RESP;
          cnt_nx_s   = 4'd0;
        end else if (accept_s) begin
          state_nx_s = RSP_WAIT;
          cnt_nx_s   = CNT_INIT;
        end else begin
          state_nx_s = RSP_IDLE;
          cnt_nx_s   = 4'd0;
        end
      end
      RSP_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nx_s = RSP_RESP;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx_s = RSP_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // State, captured response and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RSP_IDLE;
      cnt_r       <= 4'd0;
      data_ok_r   <= 1'b0;
      data_r      <= 32'd0;
      ierr_r      <= 1'b0;
      pend_data_r <= 32'd0;
      pend_err_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      data_ok_r <= enter_resp_s;
      if (accept_s) begin
        pend_data_r <= rd_word_s;
        pend_err_r  <= err_s;
      end
      // Single-cycle latency delivers the word read on this very edge.
      if (enter_resp_s) begin
        data_r <= from_wait_s ? pend_data_r : rd_word_s;
        ierr_r <= from_wait_s ? pend_err_r  : err_s;
      end else begin
        ierr_r <= 1'b0;
      end
    end
  end

  assign iresp.addr_ok = addr_ok_s;
  assign iresp.data_ok = data_ok_r;
  assign iresp.data    = data_r;
  assign ierr          = ierr_r;

endmodule

// File: tb/tb_ibus_rom_responder.sv
// Randomised bench for ibus_rom_responder at latencies 1, 3 and 4 against a
// transaction-level model (word memory plus expected-response queues).
module tb_ibus_rom_responder;
  import ibus_rom_responder_pkg::*;

  localparam int          NDUT  = 3;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [31:0] FILL  = 32'hd503_201f;

  typedef struct { int unsigned due; logic [31:0] data; logic err; } exp_t;
  typedef struct { logic [11:0] idx; logic [31:0] data; } ld_t;

  logic        clk;
  logic        reset;
  ibus_req_t   ireq  [NDUT];
  ibus_resp_t  iresp [NDUT];
  logic        ierr  [NDUT];
  logic        load_en;
  logic [11:0] load_idx;
  logic [31:0] load_data;

  int          lat_tab   [NDUT];
  logic [31:0] mem_m     [DEPTH];
  exp_t        sb_q      [NDUT][$];
  logic [63:0] rq_q      [NDUT][$];
  ld_t         ld_q[$];
  logic        acc_prev  [NDUT];
  logic [31:0] last_data [NDUT];
  int unsigned cyc;
  bit          rand_gap;
  bit          rand_load;
  int          n_cmp;
  int          n_bad;

  ibus_rom_responder #(.LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .ireq(ireq[0]), .iresp(iresp[0]), .ierr(ierr[0]),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data));
  ibus_rom_responder #(.LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .ireq(ireq[1]), .iresp(iresp[1]), .ierr(ierr[1]),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data));
  ibus_rom_responder #(.LATENCY(4)) u_dut2 (
    .clk(clk), .reset(reset), .ireq(ireq[2]), .iresp(iresp[2]), .ierr(ierr[2]),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Expected response straight from the address rules and the model memory.
  function automatic exp_t model_resp(input logic [63:0] a, input int unsigned due);
    exp_t e;
    e.due = due;
    e.err = ((a % 64'd4) != 64'd0) || (a < BASE) || (((a - BASE) / 64'd4) >= 64'(DEPTH));
    if (e.err) e.data = FILL;
    else       e.data = mem_m[int'((a - BASE) / 64'd4)];
    return e;
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    case (sel)
      0:       return BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      1:       return BASE - 64'(4 * $urandom_range(1, 8));
      2:       return BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 15));
      default: return BASE + 64'(4 * $urandom_range(0, 63));
    endcase
  endfunction

  function automatic bit busy();
    for (int k = 0; k < NDUT; k++) begin
      if (rq_q[k].size() != 0 || sb_q[k].size() != 0) return 1'b1;
      if (ireq[k].valid && !acc_prev[k]) return 1'b1;
    end
    return ld_q.size() != 0;
  endfunction

  task automatic check_reset_outputs(input string when);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s.dut%0d.addr_ok", when, k), iresp[k].addr_ok, 64'd0);
      chk($sformatf("%s.dut%0d.data_ok", when, k), iresp[k].data_ok, 64'd0);
      chk($sformatf("%s.dut%0d.data", when, k), iresp[k].data, 64'd0);
      chk($sformatf("%s.dut%0d.ierr", when, k), ierr[k], 64'd0);
    end
  endtask

  // One cycle: drive at the falling edge, check 1 time unit later.
  task automatic step();
    ld_t  ld;
    exp_t e;
    bit   exp_ok;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (!ireq[k].valid || acc_prev[k]) begin
        if (rq_q[k].size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
          ireq[k].valid = 1'b1;
          ireq[k].addr  = rq_q[k].pop_front();
        end else begin
          ireq[k].valid = 1'b0;
          ireq[k].addr  = {$urandom, $urandom};
        end
      end
      acc_prev[k] = 1'b0;
    end
    if (ld_q.size() > 0) begin
      ld = ld_q.pop_front();
      load_en = 1'b1; load_idx = ld.idx; load_data = ld.data;
    end else if (rand_load && $urandom_range(0, 3) == 0) begin
      load_en = 1'b1; load_idx = 12'($urandom_range(0, 63)); load_data = $urandom;
    end else begin
      load_en = 1'b0;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      if (sb_q[k].size() > 0 && sb_q[k][0].due == cyc) begin
        e = sb_q[k].pop_front();
        chk($sformatf("dut%0d.data_ok", k), iresp[k].data_ok, 64'd1);
        chk($sformatf("dut%0d.data", k), iresp[k].data, e.data);
        chk($sformatf("dut%0d.ierr", k), ierr[k], e.err);
        last_data[k] = e.data;
      end else begin
        chk($sformatf("dut%0d.no_data_ok", k), iresp[k].data_ok, 64'd0);
        chk($sformatf("dut%0d.ierr_idle", k), ierr[k], 64'd0);
        chk($sformatf("dut%0d.data_hold", k), iresp[k].data, last_data[k]);
      end
      // A new request is taken only once nothing is left outstanding.
      exp_ok = ireq[k].valid && (sb_q[k].size() == 0);
      chk($sformatf("dut%0d.addr_ok", k), iresp[k].addr_ok, exp_ok);
      if (exp_ok) begin
        sb_q[k].push_back(model_resp(ireq[k].addr, cyc + lat_tab[k]));
        acc_prev[k] = 1'b1;
      end
    end
    if (load_en) mem_m[load_idx] = load_data;
  endtask

  task automatic drain();
    int n = 0;
    while (busy() && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", busy(), 64'd0);
    step();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    reset   = 1'b0;
    load_en = 1'b0;
    ld_q.delete();
    for (int k = 0; k < NDUT; k++) begin
      ireq[k].valid = 1'b0;
      acc_prev[k]   = 1'b0;
      last_data[k]  = 32'd0;
      sb_q[k].delete();
      rq_q[k].delete();
    end
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rand_gap = 1'b0; rand_load = 1'b0;
    lat_tab = '{1, 3, 4};
    reset = 1'b0; load_en = 1'b0; load_idx = 12'd0; load_data = 32'd0;
    for (int k = 0; k < NDUT; k++) begin
      ireq[k] = '0; acc_prev[k] = 1'b0; last_data[k] = 32'd0;
    end
    // Store is filled through the load port while the responders sit in reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_idx  = 12'(i);
      load_data = (i == 0) ? 32'h9100_0420 : $urandom;
      mem_m[i]  = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    rq_q[0].push_back(BASE);
    drain();

    rq_q[1].push_back(BASE + 64'h4);
    rq_q[1].push_back(BASE + 64'h8);
    drain();

    rq_q[0].push_back(BASE);
    rq_q[0].push_back(BASE + 64'h4);
    rq_q[0].push_back(BASE + 64'h8);
    drain();

    for (int k = 0; k < NDUT; k++) begin
      rq_q[k].push_back(BASE + 64'h2);
      rq_q[k].push_back(64'h7fff_fffc);
      rq_q[k].push_back(BASE + 64'h4000);
    end
    drain();

    ld_q.push_back('{idx: 12'd5, data: 32'hAAAA_AAAA});
    rq_q[0].push_back(BASE + 64'h14);
    drain();
    rq_q[0].push_back(BASE + 64'h14);
    drain();

    rq_q[2].push_back(BASE + 64'h10);
    step();
    step();
    step();
    reset_mid();
    step();
    step();
    rq_q[2].push_back(BASE + 64'hc);
    drain();

    rand_gap  = 1'b1;
    rand_load = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (rq_q[k].size() < 2) rq_q[k].push_back(rand_addr());
      end
      step();
    end
    rand_load = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
